// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Sequencer for a multi-cycle MIPS datapath with a shared memory, an IR, a
// register file and a single ALU. Each instruction is stepped through
// FETCH / DECODE / EXECUTE / MEM / WB. Memory states stall on mem_ready, and
// every legal instruction bumps the retired-instruction counter on its final
// cycle.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode[5:0]       IR[31:26]; sampled only in DECODE and MEMADR
//   mem_ready         memory access completes this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source[1:0]    datapath control strobes
//   illegal_op        one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]        current state encoding, for debug
//   retired[CNT_W-1:0] retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_EXECI  = 4'd11,
        S_ALUIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_s;

    // State and retired-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            retired_q <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and control decode. Strobes are decoded straight from
    // state_q, so an asynchronous reset drops every enable immediately.
    always_comb begin
        state_d       = state_q;
        retire_s      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR latch and PC+4 only on the cycle the read completes.
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while decoding.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: state_d = S_EXEC;
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDI:  state_d = S_EXECI;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    // Opcode changed under us: abandon and refetch.
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEMWR;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire_s      = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXECI: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ALUIWB;
            end
            S_ALUIWB: begin
                reg_write = 1'b1;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Retired counter update; wraps naturally at 2^CNT_W.
    always_comb begin
        if (retire_s) begin
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_d = retired_q;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic             mem_ready = 1'b1;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic [15:0]      ctrl_s;

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    assign ctrl_s = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, alu_op, pc_source};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
    endfunction

    // Control table: which strobes each numbered step of an instruction drives.
    function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
        logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa} = 10'b0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            1:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pw = mr; end
            2:  asb = 2'b11;
            3:  begin asa = 1'b1; asb = 2'b10; end
            4:  begin mrd = 1'b1; iod = 1'b1; end
            5:  begin rw = 1'b1; m2r = 1'b1; end
            6:  begin mwr = 1'b1; iod = 1'b1; end
            7:  begin asa = 1'b1; aop = 2'b10; end
            8:  begin rw = 1'b1; rd = 1'b1; end
            9:  begin asa = 1'b1; aop = 2'b01; pwc = 1'b1; psrc = 2'b01; end
            10: begin pw = 1'b1; psrc = 2'b10; end
            11: begin asa = 1'b1; asb = 2'b10; end
            12: rw = 1'b1;
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] jk();
        return 6'($urandom);
    endfunction

    task automatic check_now(input int st, input logic mr, input logic [5:0] op);
        check_eq("state", 32'(state), 32'(st));
        check_eq("ctrl", 32'(ctrl_s), 32'(exp_ctrl(st, mr)));
        check_eq("illegal_op", 32'(illegal_op), 32'((st == 2) && !is_legal(op)));
        check_eq("retired", 32'(retired), 32'(exp_ret));
    endtask

    // One clock cycle: drive at negedge, check, then account for retirement.
    task automatic step(input int st, input logic mr, input bit ret, input logic [5:0] op);
        @(negedge clk);
        mem_ready = mr;
        opcode    = op;
        #1;
        check_now(st, mr, op);
        if (ret) exp_ret = exp_ret + 1'b1;
    endtask

    // Expected cycle sequence of one instruction; fw/mw are stall cycles.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) step(1, 1'b0, 1'b0, jk());
        step(1, 1'b1, 1'b0, jk());
        step(2, rb(), 1'b0, op);
        case (op)
            6'b000000: begin step(7, rb(), 1'b0, jk()); step(8, rb(), 1'b1, jk()); end
            6'b100011: begin
                step(3, rb(), 1'b0, op);
                for (int i = 0; i < mw; i++) step(4, 1'b0, 1'b0, jk());
                step(4, 1'b1, 1'b0, jk());
                step(5, rb(), 1'b1, jk());
            end
            6'b101011: begin
                step(3, rb(), 1'b0, op);
                for (int i = 0; i < mw; i++) step(6, 1'b0, 1'b0, jk());
                step(6, 1'b1, 1'b1, jk());
            end
            6'b000100: step(9, rb(), 1'b1, jk());
            6'b000010: step(10, rb(), 1'b1, jk());
            6'b001000: begin step(11, rb(), 1'b0, jk()); step(12, rb(), 1'b1, jk()); end
            default: ;
        endcase
    endtask

    function automatic logic [5:0] pick_op(input bit legal_only);
        logic [5:0] op;
        case ($urandom_range(0, legal_only ? 5 : 6))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = 6'b001000;
            default: begin
                op = jk();
                while (is_legal(op)) op = jk();
            end
        endcase
        return op;
    endfunction

    initial begin
        // Reset held low.
        #12;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_retired", 32'(retired), 32'd0);
        check_eq("rst_illegal", 32'(illegal_op), 32'd0);
        // Release: IDLE for exactly one cycle.
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_now(0, 1'b1, 6'd0);

        // Directed: R-type, lw with 2 waits, sw/beq/j, illegal.
        run_instr(6'b000000, 0, 0);
        run_instr(6'b100011, 0, 2);
        run_instr(6'b101011, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111111, 0, 0);

        // Randomized instruction mix with random stalls.
        for (int n = 0; n < 40; n++)
            run_instr(pick_op(1'b0), $urandom_range(0, 2), $urandom_range(0, 2));

        // Reset dropped during a stalled store.
        step(1, 1'b1, 1'b0, jk());
        step(2, 1'b1, 1'b0, 6'b101011);
        step(3, 1'b1, 1'b0, 6'b101011);
        step(6, 1'b0, 1'b0, jk());
        step(6, 1'b0, 1'b0, jk());
        #1 rst_n = 1'b0;
        #1;
        check_eq("midrst_mem_write", 32'(mem_write), 32'd0);
        check_eq("midrst_state", 32'(state), 32'd0);
        check_eq("midrst_ctrl", 32'(ctrl_s), 32'd0);
        check_eq("midrst_retired", 32'(retired), 32'd0);
        exp_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_now(0, 1'b1, 6'd0);

        // 17 legal instructions wrap the 4-bit counter to 1.
        for (int n = 0; n < 17; n++)
            run_instr(pick_op(1'b1), $urandom_range(0, 1), $urandom_range(0, 1));
        @(negedge clk);
        #1;
        check_eq("wrap_retired", 32'(retired), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
